pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It merges the ID-stage load-use stall request, EX-stage multi-cycle operation sequencing (MADD/MSUB, DIV) and the exception flush request into one per-stage stall vector. It owns the multi-cycle counter so EX and ID need no cycle bookkeeping of their own. It sits beside the pipeline registers; every `*_reg` stage latch consumes `stall_o`.

## Interface
- `MADD_CYCLES`, default 2: total EX occupancy of MADD/MSUB, in cycles (2..2^CNT_W-1).
- `DIV_CYCLES`, default 34: total EX occupancy of DIV/DIVU, in cycles (2..2^CNT_W-1).
- `CNT_W`, default 6: width of the cycle counter.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `stallreq_id_i`  in  1: load-use hazard detected in ID (combinational, level).
- `ex_mc_start_i`  in  1: instruction in EX requests a multi-cycle op.
- `ex_mc_type_i`  in  2: 2'b01 MADD/MSUB, 2'b10 DIV; 2'b00 and 2'b11 are ignored.
- `ex_mc_cancel_i`  in  1: abort the running multi-cycle op.
- `flush_req_i`  in  1: exception/flush request from MEM.
- `stall_o`  out  6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush_o`  out  1: flush all pipeline registers this cycle.
- `ex_mc_cnt_o`  out  CNT_W: index of the current multi-cycle step (0 at start).
- `ex_mc_done_o`  out  1: final cycle of a multi-cycle op; the EX result is valid.
- `busy_o`  out  1: FSM is in RUN.
- `stall_cnt_o`  out  16: saturating count of cycles with `stall_o != 0`.

## Operation
- FSM states are IDLE and RUN. The registers are `state`, `cnt` (CNT_W), `type_q` (2) and `stall_cnt` (16).
- N is MADD_CYCLES when the type is 01, and DIV_CYCLES when the type is 10.
- IDLE:
  - If `ex_mc_start_i` is high with a valid type, assert the EX stall this cycle, latch `type_q`, set `cnt`=1 and go to RUN.
  - An invalid type is ignored: no stall and no state change.
- RUN:
  - EX stall is asserted while `cnt < N-1`, and `cnt` increments each cycle.
  - When `cnt == N-1`: `ex_mc_done_o`=1, EX stall is deasserted, then next state is IDLE and `cnt`=0.
- `ex_mc_start_i` is ignored in RUN.
- `ex_mc_cancel_i` in RUN: next state is IDLE and `cnt`=0. EX stall is dropped in the same cycle and there is no done pulse. It is ignored in IDLE.
- `ex_mc_cnt_o` is 0 in IDLE (including the start cycle) and equals `cnt` in RUN.
- Stall vector priority is flush > EX stall > ID stall > none:
  - flush: `stall_o`=6'b000000 and `flush_o`=1.
  - EX stall: 6'b001111.
  - ID stall: 6'b000111.
  - none: 6'b000000.
- `flush_req_i` in any state: next state is IDLE and `cnt`=0. It overrides cancel, start and `stallreq_id_i` in the same cycle.
- `stall_cnt` increments on every cycle with a nonzero `stall_o` and saturates at 16'hFFFF.
- Reset (`rst`=0): state IDLE, `cnt` 0, `type_q` 0, `stall_cnt` 0.
  - All outputs are 0 while `rst` is low, regardless of the other inputs.
  - Reset asserted mid-operation abandons the op with no done pulse.

## Timing
- `stall_o`, `flush_o`, `ex_mc_done_o` and `busy_o` are combinational from state and the current inputs; they are valid in the same cycle as a request.
- A multi-cycle op spans exactly N cycles, counting the start cycle as cycle 0:
  - EX stall is high in cycles 0..N-2.
  - Done is high in cycle N-1.
  - EX advances at the end of cycle N-1.
- Back-to-back ops: a new start is accepted in the cycle after done (IDLE). The gap between two done pulses is at least N cycles.
- Simultaneous `stallreq_id_i` and an active EX stall: the output is 6'b001111; the ID request is absorbed.
- `stall_cnt_o` updates one cycle after the stalled cycle.

## Test plan
- Reset with all inputs high, then release:
  - while `rst` is low, every output is 0;
  - after release, the first cycle with no requests gives `stall_o`=0 and `busy_o`=0.
- MADD start (type 01, N=2):
  - cycle 0: `stall_o`=6'b001111, `ex_mc_cnt_o`=0;
  - cycle 1: `stall_o`=0, `ex_mc_done_o`=1, `ex_mc_cnt_o`=1;
  - cycle 2: `busy_o`=0;
  - `stall_cnt_o`=1.
- DIV start (type 10, N=34):
  - stall is high for 33 cycles;
  - done pulses once in cycle 33 with `ex_mc_cnt_o`=33;
  - `stallreq_id_i` pulsed during RUN leaves `stall_o`=6'b001111.
- DIV with `ex_mc_cancel_i` at `cnt`=10:
  - `stall_o`=0 in the same cycle;
  - no done pulse;
  - the next cycle is IDLE with `ex_mc_cnt_o`=0.
- `flush_req_i` together with `stallreq_id_i` and `ex_mc_start_i` in IDLE:
  - `flush_o`=1 and `stall_o`=0;
  - the FSM stays IDLE;
  - the next cycle with `stallreq_id_i` alone gives 6'b000111.
- Drive `stallreq_id_i` for 70000 cycles: `stall_cnt_o` saturates at 16'hFFFF.
- Async `rst` low mid-DIV: outputs go to 0 immediately; after release the FSM is IDLE.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller for the five-stage core.
// Merges the ID load-use stall, EX multi-cycle sequencing (MADD/MSUB, DIV)
// and the exception flush into one per-stage stall vector. It owns the
// multi-cycle step counter.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stallreq_id_i     load-use hazard from ID (level)
//   ex_mc_start_i     EX requests a multi-cycle op
//   ex_mc_type_i      2'b01 MADD/MSUB, 2'b10 DIV, other codes ignored
//   ex_mc_cancel_i    abort the running multi-cycle op
//   flush_req_i       exception/flush request from MEM
//   stall_o           {WB, MEM, EX, ID, IF, PC} stall enables
//   flush_o           flush all pipeline registers this cycle
//   ex_mc_cnt_o       current multi-cycle step (0 in IDLE)
//   ex_mc_done_o      final cycle of a multi-cycle op
//   busy_o            a multi-cycle op is running
//   stall_cnt_o       saturating count of stalled cycles
module pipe_ctrl #(
  parameter int unsigned MADD_CYCLES = 2,
  parameter int unsigned DIV_CYCLES  = 34,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             ex_mc_start_i,
  input  logic [1:0]       ex_mc_type_i,
  input  logic             ex_mc_cancel_i,
  input  logic             flush_req_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] ex_mc_cnt_o,
  output logic             ex_mc_done_o,
  output logic             busy_o,
  output logic [15:0]      stall_cnt_o
);

  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallNone = 6'b000000;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       type_q;
  logic [15:0]      stall_cnt_q;

  logic             start_ok;
  logic             in_run;
  logic             at_last;
  logic             ex_stall;
  logic [CNT_W-1:0] n_last;

  // Last step index (N-1) of the op latched in type_q.
  always_comb begin
    n_last = CNT_W'(MADD_CYCLES - 1);
    if (type_q == 2'b10) begin
      n_last = CNT_W'(DIV_CYCLES - 1);
    end
  end

  always_comb begin
    in_run   = (state_q == StRun);
    start_ok = (state_q == StIdle) && ex_mc_start_i &&
               ((ex_mc_type_i == 2'b01) || (ex_mc_type_i == 2'b10));
    at_last  = in_run && (cnt_q == n_last);
    // Cancel drops the EX stall in the same cycle it is seen.
    ex_stall = start_ok || (in_run && !at_last && !ex_mc_cancel_i);
  end

  // Outputs are combinational and forced low while reset is held.
  always_comb begin
    stall_o      = StallNone;
    flush_o      = 1'b0;
    ex_mc_cnt_o  = '0;
    ex_mc_done_o = 1'b0;
    busy_o       = 1'b0;
    stall_cnt_o  = stall_cnt_q;
    if (rst) begin
      if (flush_req_i) begin
        flush_o = 1'b1;
      end else if (ex_stall) begin
        stall_o = StallEx;
      end else if (stallreq_id_i) begin
        stall_o = StallId;
      end
      // An abandoned op (cancel or flush) never reports done.
      ex_mc_done_o = at_last && !ex_mc_cancel_i && !flush_req_i;
      busy_o       = in_run;
      ex_mc_cnt_o  = in_run ? cnt_q : '0;
    end else begin
      stall_cnt_o = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      type_q      <= 2'b00;
      stall_cnt_q <= 16'h0000;
    end else begin
      if ((stall_o != StallNone) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_req_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_ok) begin
              state_q <= StRun;
              type_q  <= ex_mc_type_i;
              cnt_q   <= CNT_W'(1);
            end
          end
          StRun: begin
            if (ex_mc_cancel_i || at_last) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int MaddN = 2;
  localparam int DivN  = 34;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id_i;
  logic       ex_mc_start_i;
  logic [1:0] ex_mc_type_i;
  logic       ex_mc_cancel_i;
  logic       flush_req_i;
  logic [5:0] stall_o;
  logic       flush_o;
  logic [5:0] ex_mc_cnt_o;
  logic       ex_mc_done_o;
  logic       busy_o;
  logic [15:0] stall_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_ctrl #(
    .MADD_CYCLES(MaddN),
    .DIV_CYCLES (DivN),
    .CNT_W      (6)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .ex_mc_start_i (ex_mc_start_i),
    .ex_mc_type_i  (ex_mc_type_i),
    .ex_mc_cancel_i(ex_mc_cancel_i),
    .flush_req_i   (flush_req_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .ex_mc_cnt_o   (ex_mc_cnt_o),
    .ex_mc_done_o  (ex_mc_done_o),
    .busy_o        (busy_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) begin
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: an op is "active" with a step index into N steps.
  bit m_active = 0;
  int m_step   = 0;
  int m_n      = 0;
  int m_sc     = 0;

  always @(negedge clk) begin
    logic [5:0] e_stall;
    bit         e_done;
    bit         valid_type;
    if (!rst) begin
      check("rst_stall", 32'(stall_o), 0);
      check("rst_flush", 32'(flush_o), 0);
      check("rst_cnt", 32'(ex_mc_cnt_o), 0);
      check("rst_done", 32'(ex_mc_done_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_scnt", 32'(stall_cnt_o), 0);
      m_active = 0;
      m_step   = 0;
      m_sc     = 0;
    end else begin
      valid_type = (ex_mc_type_i == 2'b01) || (ex_mc_type_i == 2'b10);
      e_stall = 6'b000000;
      e_done  = 0;
      if (!flush_req_i) begin
        if ((!m_active && ex_mc_start_i && valid_type) ||
            (m_active && m_step < m_n - 1 && !ex_mc_cancel_i)) e_stall = 6'b001111;
        else if (stallreq_id_i) e_stall = 6'b000111;
        e_done = m_active && (m_step == m_n - 1) && !ex_mc_cancel_i;
      end
      check("stall", 32'(stall_o), 32'(e_stall));
      check("flush", 32'(flush_o), 32'(flush_req_i));
      check("done", 32'(ex_mc_done_o), 32'(e_done));
      check("busy", 32'(busy_o), 32'(m_active));
      check("mc_cnt", 32'(ex_mc_cnt_o), m_active ? m_step : 0);
      check("stall_cnt", 32'(stall_cnt_o), m_sc);
      if (e_stall != 0 && m_sc < 65535) m_sc++;
      if (flush_req_i) begin
        m_active = 0;
        m_step   = 0;
      end else if (!m_active) begin
        if (ex_mc_start_i && valid_type) begin
          m_active = 1;
          m_step   = 1;
          m_n      = (ex_mc_type_i == 2'b01) ? MaddN : DivN;
        end
      end else if (ex_mc_cancel_i || m_step == m_n - 1) begin
        m_active = 0;
        m_step   = 0;
      end else begin
        m_step++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id_i  = 0;
    ex_mc_start_i  = 0;
    ex_mc_type_i   = 2'b00;
    ex_mc_cancel_i = 0;
    flush_req_i    = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int dones;
    int done_at;
    // Reset held with every input high.
    rst = 0;
    stallreq_id_i  = 1;
    ex_mc_start_i  = 1;
    ex_mc_type_i   = 2'b11;
    ex_mc_cancel_i = 1;
    flush_req_i    = 1;
    repeat (3) tick();
    @(negedge clk);
    check("lit_rst_flush", 32'(flush_o), 0);
    check("lit_rst_stall", 32'(stall_o), 0);
    tick();
    idle_inputs();
    tick();
    rst = 1;
    @(negedge clk);
    check("lit_post_rst_stall", 32'(stall_o), 0);
    check("lit_post_rst_busy", 32'(busy_o), 0);
    tick();

    // MADD, N=2.
    ex_mc_start_i = 1;
    ex_mc_type_i  = 2'b01;
    @(negedge clk);
    check("lit_madd_c0_stall", 32'(stall_o), 32'h0F);
    check("lit_madd_c0_cnt", 32'(ex_mc_cnt_o), 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("lit_madd_c1_stall", 32'(stall_o), 0);
    check("lit_madd_c1_done", 32'(ex_mc_done_o), 1);
    check("lit_madd_c1_cnt", 32'(ex_mc_cnt_o), 1);
    tick();
    @(negedge clk);
    check("lit_madd_c2_busy", 32'(busy_o), 0);
    check("lit_madd_scnt", 32'(stall_cnt_o), 1);
    tick();

    // Invalid type is ignored.
    ex_mc_start_i = 1;
    ex_mc_type_i  = 2'b11;
    @(negedge clk);
    check("lit_bad_type_stall", 32'(stall_o), 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("lit_bad_type_busy", 32'(busy_o), 0);
    tick();

    // DIV, N=34, with an ID request during RUN.
    stalls = 0;
    dones  = 0;
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      ex_mc_start_i = (i == 0);
      ex_mc_type_i  = 2'b10;
      stallreq_id_i = (i == 5);
      @(negedge clk);
      if (stall_o == 6'b001111) stalls++;
      if (ex_mc_done_o) begin
        dones++;
        done_at = i;
        check("lit_div_done_cnt", 32'(ex_mc_cnt_o), 33);
      end
      if (i == 5) check("lit_div_id_absorbed", 32'(stall_o), 32'h0F);
      tick();
    end
    idle_inputs();
    check("lit_div_stall_cycles", 32'(stalls), 33);
    check("lit_div_done_count", 32'(dones), 1);
    check("lit_div_done_cycle", 32'(done_at), 33);

    // DIV cancelled at cnt=10.
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      ex_mc_start_i  = (i == 0);
      ex_mc_type_i   = 2'b10;
      ex_mc_cancel_i = (i == 10);
      @(negedge clk);
      if (ex_mc_done_o) dones++;
      if (i == 10) begin
        check("lit_cancel_cnt", 32'(ex_mc_cnt_o), 10);
        check("lit_cancel_stall", 32'(stall_o), 0);
      end
      if (i == 11) begin
        check("lit_cancel_busy", 32'(busy_o), 0);
        check("lit_cancel_next_cnt", 32'(ex_mc_cnt_o), 0);
      end
      if (i == 12) check("lit_cancel_scnt", 32'(stall_cnt_o), 44);
      tick();
    end
    idle_inputs();
    check("lit_cancel_no_done", 32'(dones), 0);

    // Flush beats start and ID request in IDLE.
    flush_req_i   = 1;
    stallreq_id_i = 1;
    ex_mc_start_i = 1;
    ex_mc_type_i  = 2'b01;
    @(negedge clk);
    check("lit_flush_flush", 32'(flush_o), 1);
    check("lit_flush_stall", 32'(stall_o), 0);
    tick();
    flush_req_i   = 0;
    ex_mc_start_i = 0;
    @(negedge clk);
    check("lit_flush_idle", 32'(busy_o), 0);
    check("lit_flush_id_stall", 32'(stall_o), 32'h07);
    tick();

    // Saturation of the stall counter.
    repeat (70000) tick();
    idle_inputs();
    @(negedge clk);
    check("lit_scnt_sat", 32'(stall_cnt_o), 32'hFFFF);
    tick();

    // Asynchronous reset in the middle of a DIV.
    ex_mc_start_i = 1;
    ex_mc_type_i  = 2'b10;
    tick();
    ex_mc_start_i = 0;
    repeat (5) tick();
    stallreq_id_i = 1;
    #2;
    rst = 0;
    #1;
    check("lit_async_stall", 32'(stall_o), 0);
    check("lit_async_busy", 32'(busy_o), 0);
    check("lit_async_cnt", 32'(ex_mc_cnt_o), 0);
    check("lit_async_scnt", 32'(stall_cnt_o), 0);
    tick();
    idle_inputs();
    tick();
    rst = 1;
    @(negedge clk);
    check("lit_after_rst_busy", 32'(busy_o), 0);
    check("lit_after_rst_done", 32'(ex_mc_done_o), 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
